// File: rtl/k2_run_pkg.sv
// Shared types for the K2 run/step sequencer.
package k2_run_pkg;

   localparam int SPEED_W = 3;

   typedef enum logic [1:0] {
      STEP   = 2'b00,
      RUN    = 2'b01,
      HALTED = 2'b10
   } run_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, level qualifier and
// single-cycle rising-edge press output. Generic, reusable for any board button.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic press_o
);

   localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [QW-1:0] QUAL_LAST = QW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_dly_q;
   logic          press_q;
   logic [QW-1:0] qual_q;

   // Synchronise, qualify a level change over DEBOUNCE_CYCLES differing samples,
   // then register the rising edge of the accepted level as a one-cycle press.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
         qual_q      <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         if (sync2_q == level_q) begin
            qual_q <= '0;
         end else if (qual_q == QUAL_LAST) begin
            level_q <= sync2_q;
            qual_q  <= '0;
         end else begin
            qual_q <= qual_q + QW'(1);
         end
         level_dly_q <= level_q;
         press_q     <= level_q & ~level_dly_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/k2_run_controller.sv
// Run/step sequencer producing the K2 processor clock-enable pulse.
//
// state  | meaning
// -------+--------------------------------------------------------------
// STEP   | one cpu_en pulse per debounced button press
// RUN    | free-run: pulse every BASE_DIV << speed cycles
// HALTED | processor finished; cpu_en held low until reset
module k2_run_controller
   import k2_run_pkg::*;
#(
   parameter int BASE_DIV        = 1_562_500,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run_sw,
   input  logic [SPEED_W-1:0] speed,
   input  logic               step_btn,
   input  logic               halt,
   output logic               cpu_en,
   output logic [1:0]         state_o,
   output logic [CNT_W-1:0]   step_cnt
);

   // Seven extra bits cover the largest shift; for a power-of-two BASE_DIV the
   // shifted value wraps to zero and the -1 then yields the correct all-ones terminal.
   localparam int DIV_W = $clog2(BASE_DIV) + 7;

   run_state_t       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             cpu_en_q, cpu_en_d;
   logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic [DIV_W-1:0] terminal;
   logic             press;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_step_btn (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (step_btn),
      .press_o (press)
   );

   assign terminal = (DIV_W'(BASE_DIV) << speed) - DIV_W'(1);

   // Next-state decode; halt outranks any pulse source, leaving RUN never pulses.
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      cpu_en_d = 1'b0;
      unique case (state_q)
         STEP: begin
            if (halt) begin
               state_d = HALTED;
            end else begin
               cpu_en_d = press;
               if (run_sw) begin
                  state_d = RUN;
                  div_d   = '0;
               end
            end
         end
         RUN: begin
            if (halt) begin
               state_d = HALTED;
            end else if (!run_sw) begin
               state_d = STEP;
               div_d   = '0;
            end else if (div_q >= terminal) begin
               cpu_en_d = 1'b1;
               div_d    = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = STEP;
            div_d   = '0;
         end
      endcase
      step_cnt_d = (cpu_en_d && (step_cnt_q != '1)) ? step_cnt_q + CNT_W'(1) : step_cnt_q;
   end

   // Register state, divider, the enable pulse and the saturating pulse count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= STEP;
         div_q      <= '0;
         cpu_en_q   <= 1'b0;
         step_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         cpu_en_q   <= cpu_en_d;
         step_cnt_q <= step_cnt_d;
      end
   end

   assign cpu_en   = cpu_en_q;
   assign state_o  = state_q;
   assign step_cnt = step_cnt_q;

endmodule
